// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one request at a time over valid/ready,
// a programmable number of wait states, then a one-cycle response with data and error flag.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]       wait_cnt;
    logic             lat_write;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [31:0]      mem [DEPTH];
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             ready_int;
    logic             accept;
    logic             enter_resp;
    logic             op_write;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic             op_err;
    logic [IDX_W-1:0] op_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WAIT leaves on the edge where the counter would reach zero, so a
    // request occupies exactly WAIT_CYCLES+1 cycles before the next accept.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESP: begin
                if (req_valid) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    next_state = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready_int  = (state == IDLE) || (state == RESP);
        req_ready  = ready_int;
        resp_valid = (state == RESP);
        resp_rdata = (state == RESP) ? rdata_q : 32'd0;
        resp_err   = (state == RESP) ? err_q : 1'b0;
    end

    assign accept     = ready_int && req_valid;
    assign enter_resp = (next_state == RESP) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt  <= 4'(WAIT_CYCLES);
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // With no wait states the request is serviced on its own accept edge,
    // so the live inputs are used instead of the latched copy.
    always_comb begin
        op_write = (state == WAIT) ? lat_write : req_write;
        op_addr  = (state == WAIT) ? lat_addr  : req_addr;
        op_wdata = (state == WAIT) ? lat_wdata : req_wdata;
        op_err   = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
        op_idx   = op_addr[IDX_W+1:2];
    end

    always_ff @(posedge clk) begin
        if (enter_resp && op_write && !op_err) begin
            mem[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (!op_write && !op_err) ? mem[op_idx] : 32'd0;
            err_q   <= op_err;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, each compared
// every cycle against a timestamp-based transaction model with its own copy of memory.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 0;

    bit          pend  [2];
    int          due   [2];
    logic        pw    [2];
    logic [31:0] pa    [2];
    logic [31:0] pd    [2];
    logic [31:0] mem_m [2][DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // A request seen with ready at sample c is accepted at edge c+1 and its
    // response is visible in sample c+1+WAIT_CYCLES; the memory effect lands then.
    task automatic modelStep(input int d);
        logic        eready;
        logic        evalid;
        logic        eerr;
        logic [31:0] erdata;
        logic [31:0] widx;
        int          c;
        c = cyc;
        eready = 1'b1;
        evalid = 1'b0;
        eerr   = 1'b0;
        erdata = 32'd0;
        if (pend[d] && due[d] == c) begin
            evalid  = 1'b1;
            pend[d] = 1'b0;
            widx    = pa[d] >> 2;
            eerr    = (pa[d][1:0] != 2'b00) || (widx >= 32'(DEPTH));
            if (!eerr) begin
                if (pw[d]) mem_m[d][widx[5:0]] = pd[d];
                else erdata = mem_m[d][widx[5:0]];
            end
        end else if (pend[d]) begin
            eready = 1'b0;
        end
        checkOutput($sformatf("d%0d_req_ready", d), {31'd0, req_ready[d]}, {31'd0, eready});
        checkOutput($sformatf("d%0d_resp_valid", d), {31'd0, resp_valid[d]}, {31'd0, evalid});
        checkOutput($sformatf("d%0d_resp_rdata", d), resp_rdata[d], erdata);
        checkOutput($sformatf("d%0d_resp_err", d), {31'd0, resp_err[d]}, {31'd0, eerr});
        if (rst[d]) begin
            pend[d] = 1'b0;
        end else if (eready && req_valid[d]) begin
            pend[d] = 1'b1;
            due[d]  = c + 1 + waitOf(d);
            pw[d]   = req_write[d];
            pa[d]   = req_addr[d];
            pd[d]   = req_wdata[d];
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            due[d]  = 0;
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'd0;
        end
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int d = 0; d < 2; d++) modelStep(d);
            end
        end
    end

    // Holds req_valid until the DUT takes the request; returns #1 after the accept edge
    // with req_valid still high so a following call gives back-to-back traffic.
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        logic rdy;
        bit   done;
        done = 1'b0;
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            rdy = req_ready[d];
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        checkOutput($sformatf("d%0d_accept", d), {31'd0, done}, 32'd1);
    endtask

    task automatic idleCycles(input int d, input int n);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] genAddr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return {24'd0, 6'($urandom_range(0, 15)), 2'b00};
        if (k == 6) return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (k == 7) return {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        if (k == 8) return ($urandom_range(0, 1) == 0) ? 32'h0000_0100 : 32'h0000_00FC;
        return $urandom;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idleCycles(0, 3);

        $display("[TB] store/load 0x10 with two wait states");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
        idleCycles(0, 4);
        applyStimulus(0, 1'b0, 32'h10, 32'd0);
        idleCycles(0, 4);

        $display("[TB] back-to-back stores then loads");
        applyStimulus(0, 1'b1, 32'h0, 32'd1);
        applyStimulus(0, 1'b1, 32'h4, 32'd2);
        applyStimulus(0, 1'b1, 32'h8, 32'd3);
        applyStimulus(0, 1'b0, 32'h0, 32'd0);
        applyStimulus(0, 1'b0, 32'h4, 32'd0);
        applyStimulus(0, 1'b0, 32'h8, 32'd0);
        idleCycles(0, 4);

        $display("[TB] misaligned and out-of-range requests");
        applyStimulus(0, 1'b0, 32'h13, 32'd0);
        idleCycles(0, 3);
        applyStimulus(0, 1'b1, 32'h100, 32'h5555AAAA);
        idleCycles(0, 3);
        applyStimulus(0, 1'b0, 32'h0, 32'd0);
        idleCycles(0, 4);

        $display("[TB] reset while a store is waiting");
        applyStimulus(0, 1'b1, 32'h20, 32'hCAFEF00D);
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        idleCycles(0, 5);
        applyStimulus(0, 1'b0, 32'h20, 32'd0);
        idleCycles(0, 4);

        $display("[TB] zero wait states: store then immediate load");
        applyStimulus(1, 1'b1, 32'h4, 32'h12345678);
        applyStimulus(1, 1'b0, 32'h4, 32'd0);
        idleCycles(1, 3);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d]       = ($urandom_range(0, 63) == 0);
                req_valid[d] = ($urandom_range(0, 3) != 0);
                req_write[d] = 1'($urandom_range(0, 1));
                req_addr[d]  = genAddr();
                req_wdata[d] = $urandom;
            end
            @(posedge clk);
            #1;
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        req_valid[1] = 1'b0;
        idleCycles(0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
